// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: arbitration states and grant sources.
`ifndef XLEN
`define XLEN 32
`endif

package regfile_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_t;

  typedef enum logic [1:0] {GRANT_NONE, GRANT_PIPE, GRANT_LONG} grant_src_t;

endpackage

// File: rtl/regfile_write_arbiter_result_buffer.sv
// Single-entry holding register for one long-unit result (address + data) with a valid flag.
`ifndef XLEN
`define XLEN 32
`endif

module result_buffer #(
  parameter int ADR_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] data_q;

  // load only happens while empty and clear only while full, so they never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      adr_q   <= adr_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign adr_o   = adr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback and a long-latency unit.
// Optional stall counter on StallCount is built when REGFILE_ARB_STALL_COUNT_EN is defined.
//
// state | meaning
// IDLE  | result buffer empty
// WAIT  | buffer full, pipeline has priority, starve counter running
// FORCE | buffer full, granted this cycle regardless of pipeline
`ifndef XLEN
`define XLEN 32
`endif

module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int REGISTER_COUNT = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              PipeWriteEn,
  input  logic [$clog2(REGISTER_COUNT)-1:0] PipeRdAdr,
  input  logic [`XLEN-1:0]                  PipeRd,
  output logic                              PipeStall,
  input  logic                              LongValid,
  input  logic [$clog2(REGISTER_COUNT)-1:0] LongRdAdr,
  input  logic [`XLEN-1:0]                  LongRd,
  output logic                              LongReady,
  input  logic                              LongIssue,
  input  logic [$clog2(REGISTER_COUNT)-1:0] LongIssueAdr,
  output logic [REGISTER_COUNT-1:0]         PendingMask,
  output logic                              WriteEn,
  output logic [$clog2(REGISTER_COUNT)-1:0] rd1Adr,
  output logic [`XLEN-1:0]                  Rd1,
  output logic [31:0]                       StallCount
);

  localparam int ADR_W = $clog2(REGISTER_COUNT);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t                state_q, state_d;
  logic [CNT_W-1:0]          starve_q, starve_d, starve_inc;
  logic [REGISTER_COUNT-1:0] pend_q, pend_d;
  logic                      buf_valid, accept, buf_grant, pipe_grant;
  logic [ADR_W-1:0]          buf_adr, wr_adr, adr_q;
  logic [`XLEN-1:0]          buf_data, wr_data, data_q;
  logic                      we_q;
  grant_src_t                grant_src;

  // ready is forced low during reset, not just derived from the cleared buffer
  assign LongReady  = !buf_valid && reset;
  assign accept     = LongValid && LongReady;
  assign buf_grant  = buf_valid && (!PipeWriteEn || state_q == FORCE);
  assign pipe_grant = PipeWriteEn && !buf_grant;
  assign PipeStall  = PipeWriteEn && buf_grant;

  result_buffer #(.ADR_W(ADR_W), .DATA_W(`XLEN)) u_result_buffer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .clear_i (buf_grant),
    .adr_i   (LongRdAdr),
    .data_i  (LongRd),
    .valid_o (buf_valid),
    .adr_o   (buf_adr),
    .data_o  (buf_data)
  );

  assign starve_inc = starve_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (accept) state_d = (STARVE_LIMIT == 0) ? FORCE : WAIT;
      end
      WAIT: begin
        if (buf_grant) begin
          state_d  = IDLE;
          starve_d = '0;
        end else begin
          starve_d = starve_inc;
          if (starve_inc == LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        state_d  = IDLE;
        starve_d = '0;
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

  always_comb begin
    grant_src = GRANT_NONE;
    if (buf_grant)       grant_src = GRANT_LONG;
    else if (pipe_grant) grant_src = GRANT_PIPE;
  end

  assign wr_adr  = (grant_src == GRANT_LONG) ? buf_adr  : PipeRdAdr;
  assign wr_data = (grant_src == GRANT_LONG) ? buf_data : PipeRd;

  // set beats clear when the same register is re-issued as its result drains
  always_comb begin
    pend_d = pend_q;
    if (buf_grant) pend_d[buf_adr] = 1'b0;
    if (LongIssue && LongIssueAdr != '0) pend_d[LongIssueAdr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      we_q     <= (grant_src != GRANT_NONE) && (wr_adr != '0);
      if (grant_src != GRANT_NONE) begin
        adr_q  <= wr_adr;
        data_q <= wr_data;
      end
    end
  end

  assign PendingMask = pend_q;
  assign WriteEn     = we_q;
  assign rd1Adr      = adr_q;
  assign Rd1         = data_q;

`ifdef REGFILE_ARB_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         stall_cnt_q <= '0;
    else if (PipeStall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign StallCount = stall_cnt_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued at issue and checked by a monitor.
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_write_arbiter;

  localparam int ADR_W = 5;
  localparam int XW    = `XLEN;

  logic             clk = 1'b0;
  logic             reset;
  logic             PipeWriteEn, LongValid, LongIssue;
  logic [ADR_W-1:0] PipeRdAdr, LongRdAdr, LongIssueAdr;
  logic [XW-1:0]    PipeRd, LongRd;
  logic             PipeStall, LongReady, WriteEn;
  logic [31:0]      PendingMask;
  logic [ADR_W-1:0] rd1Adr;
  logic [XW-1:0]    Rd1;
  logic [31:0]      StallCount;

  int tests_run    = 0;
  int tests_failed = 0;
  logic mon_en     = 1'b0;
  logic [ADR_W+XW-1:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.REGISTER_COUNT(32), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .PipeWriteEn  (PipeWriteEn),
    .PipeRdAdr    (PipeRdAdr),
    .PipeRd       (PipeRd),
    .PipeStall    (PipeStall),
    .LongValid    (LongValid),
    .LongRdAdr    (LongRdAdr),
    .LongRd       (LongRd),
    .LongReady    (LongReady),
    .LongIssue    (LongIssue),
    .LongIssueAdr (LongIssueAdr),
    .PendingMask  (PendingMask),
    .WriteEn      (WriteEn),
    .rd1Adr       (rd1Adr),
    .Rd1          (Rd1),
    .StallCount   (StallCount)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [ADR_W-1:0] a, input logic [XW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && reset === 1'b1 && WriteEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got adr %0d data 0x%0h, expected no write", rd1Adr, Rd1);
      end else begin
        check("write_port", {rd1Adr, Rd1}, exp_q.pop_front());
      end
    end
  end

  task automatic starve_run(input int rep);
    int k;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      PipeWriteEn  = 1'b1;
      PipeRdAdr    = 5'd9;
      PipeRd       = 32'h100 + rep * 16 + k;
      LongValid    = (i == 0);
      LongRdAdr    = 5'd11;
      LongRd       = 32'hBEEF_0000 + rep;
      LongIssue    = (i == 0);
      LongIssueAdr = 5'd11;
      if (i == 5) push(5'd11, 32'hBEEF_0000 + rep);
      else begin
        push(5'd9, 32'h100 + rep * 16 + k);
        k++;
      end
      @(negedge clk);
      check($sformatf("starve_stall_r%0d_c%0d", rep, i), PipeStall, (i == 5));
      if (i == 0) check("starve_long_ready", LongReady, 1);
      if (i == 3) check("starve_pending", PendingMask, 32'h1 << 11);
    end
    step();
    PipeWriteEn = 1'b0;
    LongValid   = 1'b0;
    LongIssue   = 1'b0;
    @(negedge clk);
    check("starve_pending_cleared", PendingMask, 0);
  endtask

  initial begin
    reset        = 1'b0;
    PipeWriteEn  = 1'b0;
    PipeRdAdr    = '0;
    PipeRd       = '0;
    LongValid    = 1'b0;
    LongRdAdr    = '0;
    LongRd       = '0;
    LongIssue    = 1'b0;
    LongIssueAdr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", WriteEn, 0);
    check("rst_adr", rd1Adr, 0);
    check("rst_data", Rd1, 0);
    check("rst_pending", PendingMask, 0);
    check("rst_long_ready", LongReady, 0);
    check("rst_stall", PipeStall, 0);
    check("rst_stall_count", StallCount, 0);

    step();
    reset  = 1'b1;
    mon_en = 1'b1;

    // plain pipeline write
    PipeWriteEn = 1'b1;
    PipeRdAdr   = 5'd5;
    PipeRd      = 32'hA5;
    push(5'd5, 32'hA5);
    @(negedge clk);
    check("t1_stall", PipeStall, 0);
    check("t1_long_ready", LongReady, 1);
    step();
    PipeWriteEn = 1'b0;
    @(negedge clk);
    check("t1_we", WriteEn, 1);

    // long result with scoreboard bit
    step();
    LongIssue    = 1'b1;
    LongIssueAdr = 5'd7;
    step();
    LongIssue = 1'b0;
    LongValid = 1'b1;
    LongRdAdr = 5'd7;
    LongRd    = 32'h1234;
    push(5'd7, 32'h1234);
    @(negedge clk);
    check("t2_pending_set", PendingMask, 32'h1 << 7);
    check("t2_ready_empty", LongReady, 1);
    step();
    LongValid = 1'b0;
    @(negedge clk);
    check("t2_ready_full", LongReady, 0);
    check("t2_stall", PipeStall, 0);
    step();
    @(negedge clk);
    check("t2_we", WriteEn, 1);
    check("t2_pending_clear", PendingMask, 0);
    check("t2_ready_back", LongReady, 1);

    // starvation and forced grant, three times
    for (int r = 0; r < 3; r++) starve_run(r);
`ifdef REGFILE_ARB_STALL_COUNT_EN
    check("stall_count", StallCount, 3);
`else
    check("stall_count", StallCount, 0);
`endif

    // writes to x0 are consumed silently
    step();
    PipeWriteEn = 1'b1;
    PipeRdAdr   = 5'd0;
    PipeRd      = 32'hDEAD;
    step();
    PipeWriteEn = 1'b0;
    @(negedge clk);
    check("x0_pipe_we", WriteEn, 0);
    step();
    LongValid = 1'b1;
    LongRdAdr = 5'd0;
    LongRd    = 32'hCAFE;
    @(negedge clk);
    check("x0_long_ready_in", LongReady, 1);
    step();
    LongValid = 1'b0;
    @(negedge clk);
    check("x0_long_ready_full", LongReady, 0);
    step();
    @(negedge clk);
    check("x0_long_we", WriteEn, 0);
    check("x0_long_ready_back", LongReady, 1);
    check("x0_pending", PendingMask, 0);

    // reset in the middle of WAIT drops the buffered result
    step();
    LongIssue    = 1'b1;
    LongIssueAdr = 5'd12;
    LongValid    = 1'b1;
    LongRdAdr    = 5'd12;
    LongRd       = 32'h5555;
    PipeWriteEn  = 1'b1;
    PipeRdAdr    = 5'd3;
    PipeRd       = 32'h301;
    push(5'd3, 32'h301);
    step();
    LongIssue = 1'b0;
    LongValid = 1'b0;
    PipeRd    = 32'h302;
    push(5'd3, 32'h302);
    @(negedge clk);
    check("t5_pending_set", PendingMask, 32'h1 << 12);
    check("t5_stall", PipeStall, 0);
    step();
    PipeRd = 32'h303;
    @(negedge clk);
    #1;
    reset       = 1'b0;
    PipeWriteEn = 1'b0;
    #1;
    check("t5_rst_pending", PendingMask, 0);
    check("t5_rst_we", WriteEn, 0);
    check("t5_rst_ready", LongReady, 0);
    step();
    step();
    reset = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("t5_after_ready", LongReady, 1);
    check("t5_after_pending", PendingMask, 0);
    check("t5_after_stall_count", StallCount, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
